pll_reset_sequencer: RTL and testbench

- Parametrised reset/PLL bring-up controller for devkit top levels.
- Drives PLL reset outputs and waits for all PLL locks, retrying on timeout.
- Stretches reset once the PLLs are stable, then releases N reset domains in order, e.g. memory first, then system.
- Replaces hard-wired PLL resets and the raw button-to-reset connection.

---
 rtl/pll_reset_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: PLL bring-up and ordered reset-domain release.
// Holds the PLLs in reset, waits for every lock (retrying on timeout),
// stretches reset while the locks stay stable, then releases the reset
// domains one at a time, lowest index first, with a fixed gap between them.
// A debounced button press re-runs the whole sequence from PLL reset.
// Optional feature macro: RESET_SEQ_LOCK_MONITOR_EN. When defined, losing any
// lock in RELEASE or RUN reasserts all domains and returns to WAIT_LOCK.
// dbg_state mirrors the FSM state register (0 PLL_RST, 1 WAIT_LOCK,
// 2 STRETCH, 3 RELEASE, 4 RUN).
module pll_reset_sequencer #(
   parameter int PLL_COUNT           = 2,
   parameter int DOMAIN_COUNT        = 2,
   parameter int DEBOUNCE_CYCLES     = 16,
   parameter int PLL_RST_CYCLES      = 8,
   parameter int LOCK_TIMEOUT_CYCLES = 1024,
   parameter int STRETCH_CYCLES      = 64,
   parameter int GAP_CYCLES          = 16
) (
   input  logic                    io_systemClk,
   input  logic                    io_asyncResetn,
   input  logic                    io_button,
   input  logic [PLL_COUNT-1:0]    io_pllLocked,
   output logic [PLL_COUNT-1:0]    io_pllRstn,
   output logic [DOMAIN_COUNT-1:0] io_domainReset,
   output logic                    io_ready,
   output logic [7:0]              io_retryCount,
   output logic [2:0]              dbg_state
);

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int MAX_P = max2(max2(max2(DEBOUNCE_CYCLES, PLL_RST_CYCLES),
                                    max2(LOCK_TIMEOUT_CYCLES, STRETCH_CYCLES)),
                               GAP_CYCLES);
   localparam int CW = $clog2(MAX_P) + 1;
   localparam int SW = (DOMAIN_COUNT > 1) ? $clog2(DOMAIN_COUNT) : 1;

   // Terminal counts: the counter starts at 0 on state entry, so an N-cycle
   // stay ends when the counter holds N-1.
   localparam logic [CW-1:0] DB_LAST      = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] PLL_RST_LAST = CW'(PLL_RST_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] STRETCH_LAST = CW'(STRETCH_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST     = CW'(GAP_CYCLES - 1);
   localparam logic [SW-1:0] SLOT_LAST    = SW'(DOMAIN_COUNT - 1);

   typedef enum logic [2:0] {
      ST_PLL_RST   = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STRETCH   = 3'd2,
      ST_RELEASE   = 3'd3,
      ST_RUN       = 3'd4
   } state_t;

   state_t               state;
   logic [CW-1:0]        cnt;
   logic [SW-1:0]        slot;
   logic [1:0]           btn_sync;
   logic [PLL_COUNT-1:0] lock_s1;
   logic [PLL_COUNT-1:0] lock_s2;
   logic [CW-1:0]        db_cnt;
   logic                 btn_pressed;
   logic                 btn_prev;
   logic                 btn_level;
   logic                 btn_rise;
   logic                 all_locked;

   // Button is active-low: the pressed level is the inverted synchronised pin.
   assign btn_level  = ~btn_sync[1];
   assign btn_rise   = btn_pressed & ~btn_prev;
   assign all_locked = &lock_s2;
   assign dbg_state  = state;

   // Two-flop synchronisers for the asynchronous button and lock inputs.
   always_ff @(posedge io_systemClk or negedge io_asyncResetn) begin
      if (!io_asyncResetn) begin
         btn_sync <= '0;
         lock_s1  <= '0;
         lock_s2  <= '0;
      end else begin
         btn_sync <= {btn_sync[0], io_button};
         lock_s1  <= io_pllLocked;
         lock_s2  <= lock_s1;
      end
   end

   // Debouncer: accept a new button level only after it has differed from
   // the accepted one for DEBOUNCE_CYCLES consecutive cycles.
   always_ff @(posedge io_systemClk or negedge io_asyncResetn) begin
      if (!io_asyncResetn) begin
         db_cnt      <= '0;
         btn_pressed <= 1'b0;
         btn_prev    <= 1'b0;
      end else begin
         btn_prev <= btn_pressed;
         if (btn_level == btn_pressed) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_LAST) begin
            btn_pressed <= btn_level;
            db_cnt      <= '0;
         end else begin
            db_cnt <= db_cnt + CW'(1);
         end
      end
   end

   // Sequencing FSM with registered outputs; a button press overrides every
   // state, including a coincident lock timeout (no retry is counted then).
   always_ff @(posedge io_systemClk or negedge io_asyncResetn) begin
      if (!io_asyncResetn) begin
         state          <= ST_PLL_RST;
         cnt            <= '0;
         slot           <= '0;
         io_pllRstn     <= '0;
         io_domainReset <= '1;
         io_ready       <= 1'b0;
         io_retryCount  <= '0;
      end else if (btn_rise) begin
         state          <= ST_PLL_RST;
         cnt            <= '0;
         slot           <= '0;
         io_pllRstn     <= '0;
         io_domainReset <= '1;
         io_ready       <= 1'b0;
`ifdef RESET_SEQ_LOCK_MONITOR_EN
      end else if (!all_locked && (state == ST_RELEASE || state == ST_RUN)) begin
         state          <= ST_WAIT_LOCK;
         cnt            <= '0;
         slot           <= '0;
         io_domainReset <= '1;
         io_ready       <= 1'b0;
`endif
      end else begin
         case (state)
            ST_PLL_RST: begin
               // Counter parks at its terminal value while the button is held.
               if (cnt != PLL_RST_LAST) begin
                  cnt <= cnt + CW'(1);
               end else if (!btn_pressed) begin
                  state      <= ST_WAIT_LOCK;
                  cnt        <= '0;
                  io_pllRstn <= '1;
               end
            end
            ST_WAIT_LOCK: begin
               if (all_locked) begin
                  state <= ST_STRETCH;
                  cnt   <= '0;
               end else if (cnt == TIMEOUT_LAST) begin
                  state      <= ST_PLL_RST;
                  cnt        <= '0;
                  io_pllRstn <= '0;
                  if (io_retryCount != 8'hFF) begin
                     io_retryCount <= io_retryCount + 8'd1;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_STRETCH: begin
               if (!all_locked) begin
                  state <= ST_WAIT_LOCK;
                  cnt   <= '0;
               end else if (cnt == STRETCH_LAST) begin
                  state          <= ST_RELEASE;
                  cnt            <= '0;
                  slot           <= '0;
                  io_domainReset <= io_domainReset << 1;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_RELEASE: begin
               // Shifting a zero in from the bottom keeps the vector thermometer-coded.
               if (cnt == GAP_LAST) begin
                  cnt <= '0;
                  if (slot == SLOT_LAST) begin
                     state    <= ST_RUN;
                     io_ready <= 1'b1;
                  end else begin
                     slot           <= slot + SW'(1);
                     io_domainReset <= io_domainReset << 1;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_RUN: begin
               io_ready <= 1'b1;
            end
            default: begin
               state <= ST_PLL_RST;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with default parameters.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_pll_reset_sequencer;

   logic       clk;
   logic       rst_n;
   logic       btn;
   logic [1:0] lock;
   logic [1:0] pll_rstn;
   logic [1:0] dom_rst;
   logic       ready;
   logic [7:0] retry;
   logic [2:0] dbg_state;

   int         n_vec = 0;
   int         n_err = 0;
   int         n;
   int         low_run;
   int         pulses;
   logic       thermo_bad = 1'b0;
   logic       seq_mon_en = 1'b0;
   logic [1:0] dom_prev = 2'b11;
   logic [1:0] exp_q[$];

   pll_reset_sequencer dut (
      .io_systemClk   (clk),
      .io_asyncResetn (rst_n),
      .io_button      (btn),
      .io_pllLocked   (lock),
      .io_pllRstn     (pll_rstn),
      .io_domainReset (dom_rst),
      .io_ready       (ready),
      .io_retryCount  (retry),
      .dbg_state      (dbg_state)
   );

   // Clock and watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic wait_dr(input logic [1:0] val, input int budget, output int cnt);
      cnt = 0;
      while (dom_rst !== val && cnt < budget) begin
         @(negedge clk);
         cnt++;
      end
      if (dom_rst !== val) chk("wait_dr_timeout", {30'd0, dom_rst}, {30'd0, val});
   endtask

   task automatic wait_ready(input int budget, output int cnt);
      cnt = 0;
      while (ready !== 1'b1 && cnt < budget) begin
         @(negedge clk);
         cnt++;
      end
      if (ready !== 1'b1) chk("wait_ready_timeout", {31'd0, ready}, 32'd1);
   endtask

   task automatic wait_pll_high(input int budget, output int cnt);
      cnt = 0;
      while (pll_rstn !== 2'b11 && cnt < budget) begin
         @(negedge clk);
         cnt++;
      end
      if (pll_rstn !== 2'b11) chk("wait_pll_timeout", {30'd0, pll_rstn}, 32'd3);
   endtask

   // Scoreboard: domain-reset transitions against the expected queue, plus
   // a thermometer-code watch over the whole run.
   always @(negedge clk) begin
      if (rst_n && dom_rst === 2'b01) thermo_bad <= 1'b1;
      if (seq_mon_en && dom_rst !== dom_prev) begin
         if (exp_q.size() == 0) chk("dr_seq_extra", {30'd0, dom_rst}, {30'd0, dom_prev});
         else chk("dr_seq", {30'd0, dom_rst}, {30'd0, exp_q.pop_front()});
      end
      dom_prev <= dom_rst;
   end

   initial begin
      rst_n = 1'b0;
      btn   = 1'b1;
      lock  = 2'b11;
      step(3);

      // Reset values
      chk("rst_pllrstn", {30'd0, pll_rstn}, 32'd0);
      chk("rst_domrst", {30'd0, dom_rst}, 32'd3);
      chk("rst_ready", {31'd0, ready}, 32'd0);
      chk("rst_retry", {24'd0, retry}, 32'd0);
      chk("rst_state", {29'd0, dbg_state}, 32'd0);

      // Nominal bring-up: 8-cycle PLL reset, 64-cycle stretch, 16-cycle gaps
      exp_q.push_back(2'b10);
      exp_q.push_back(2'b00);
      seq_mon_en = 1'b1;
      rst_n = 1'b1;
      wait_pll_high(100, n);
      chk("nom_pll_low", n, 32'd8);
      wait_dr(2'b10, 200, n);
      chk("nom_dr0_fall", n, 32'd65);
      wait_dr(2'b00, 100, n);
      chk("nom_dr1_gap", n, 32'd16);
      wait_ready(100, n);
      chk("nom_ready_gap", n, 32'd16);
      chk("nom_run_state", {29'd0, dbg_state}, 32'd4);
      chk("nom_pllrstn", {30'd0, pll_rstn}, 32'd3);
      chk("nom_seq_left", exp_q.size(), 32'd0);

      // 5-cycle button glitch in RUN is filtered out
      btn = 1'b0;
      step(5);
      btn = 1'b1;
      step(40);
      chk("glitch_ready", {31'd0, ready}, 32'd1);
      chk("glitch_domrst", {30'd0, dom_rst}, 32'd0);

      // 40-cycle press: 2 sync + 16 debounce + 1 to the outputs
      exp_q.push_back(2'b11);
      exp_q.push_back(2'b10);
      exp_q.push_back(2'b00);
      btn = 1'b0;
      wait_dr(2'b11, 100, n);
      chk("press_latency", n, 32'd19);
      chk("press_ready", {31'd0, ready}, 32'd0);
      chk("press_pllrstn", {30'd0, pll_rstn}, 32'd0);
      step(21);
      btn = 1'b1;
      wait_pll_high(100, n);
      chk("press_pll_release", n, 32'd19);
      wait_dr(2'b10, 200, n);
      chk("press_dr0_fall", n, 32'd65);
      wait_dr(2'b00, 100, n);
      chk("press_dr1_gap", n, 32'd16);
      wait_ready(100, n);
      chk("press_ready_gap", n, 32'd16);
      chk("press_seq_left", exp_q.size(), 32'd0);
      seq_mon_en = 1'b0;

      // Lock[0] drops in RUN
      lock = 2'b10;
`ifdef RESET_SEQ_LOCK_MONITOR_EN
      wait_dr(2'b11, 20, n);
      chk("mon_latency", n, 32'd3);
      chk("mon_ready", {31'd0, ready}, 32'd0);
      lock = 2'b11;
      wait_ready(400, n);
      chk("mon_rerun_ready", {31'd0, ready}, 32'd1);
`else
      step(10);
      chk("nomon_ready", {31'd0, ready}, 32'd1);
      chk("nomon_domrst", {30'd0, dom_rst}, 32'd0);
      lock = 2'b11;
      step(5);
      chk("nomon_ready_after", {31'd0, ready}, 32'd1);
`endif

      // Stretch abort: lock[1] low for one cycle, 30 cycles into STRETCH
      @(negedge clk);
      rst_n = 1'b0;
      step(2);
      rst_n = 1'b1;
      step(39);
      lock = 2'b01;
      step(1);
      lock = 2'b11;
      chk("abort_domrst", {30'd0, dom_rst}, 32'd3);
      wait_dr(2'b10, 200, n);
      chk("abort_dr0_fall", n, 32'd67);
      wait_ready(100, n);
      chk("abort_ready", n, 32'd32);

      // Lock timeout: locks low for 3000 cycles, two retries, three pulses
      @(negedge clk);
      rst_n = 1'b0;
      lock  = 2'b00;
      step(2);
      rst_n   = 1'b1;
      low_run = 0;
      pulses  = 0;
      for (int c = 0; c < 3000; c++) begin
         if (pll_rstn === 2'b00) begin
            low_run++;
         end else if (low_run > 0) begin
            pulses++;
            chk("to_pulse_width", low_run, 32'd8);
            low_run = 0;
         end
         step(1);
      end
      lock = 2'b11;
      chk("to_pulses", pulses, 32'd3);
      chk("to_retry", {24'd0, retry}, 32'd2);
      chk("to_pllrstn", {30'd0, pll_rstn}, 32'd3);
      wait_dr(2'b10, 200, n);
      chk("to_dr0_fall", n, 32'd67);
      chk("to_retry_kept", {24'd0, retry}, 32'd2);

      // Async reset mid-RELEASE takes effect without a clock edge
      step(5);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_domrst", {30'd0, dom_rst}, 32'd3);
      chk("arst_pllrstn", {30'd0, pll_rstn}, 32'd0);
      chk("arst_retry", {24'd0, retry}, 32'd0);
      chk("arst_ready", {31'd0, ready}, 32'd0);
      chk("arst_state", {29'd0, dbg_state}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step(2);

      chk("thermometer", {31'd0, thermo_bad}, 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
